// File: rtl/ram_port_seq.sv
// ram_port_seq: sequences single accesses onto an asynchronous SRAM-style
// port. Each access is SETUP, then STROBE, then HOLD (writes) or RESP (reads).
// All RAM control outputs come straight from flops.
// Optional feature: define RAM_PORT_SEQ_BURST_EN to make reads perform
// req_len+1 beats at incrementing (wrapping) addresses.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1. A read word transfers on a rising edge where rd_valid
// and rd_ready are both 1. Valid never depends combinationally on ready.
module ram_port_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [7:0]            req_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Counter loads are "cycles minus one" so the phase ends when it hits zero.
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drv_en_q;
  logic                  accept;
  logic                  last_strobe;
  logic                  resp_done;
  logic                  more_beats;

  assign accept      = req_valid && req_ready;
  assign last_strobe = (state_q == S_STROBE) && (cnt_q == 4'd0);
  assign resp_done   = (state_q == S_RESP) && rd_ready;
  assign we_d        = accept ? req_we : we_q;
  assign dbg_state   = state_q;

  // Data pins are driven only by a write access; otherwise released.
  assign ram_data = drv_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef RAM_PORT_SEQ_BURST_EN
  logic [7:0] beats_q;

  assign more_beats = (beats_q != 8'd0);

  // Remaining read beats after the current one; writes never burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beats_q <= 8'd0;
    end else if (accept) begin
      beats_q <= req_we ? 8'd0 : req_len;
    end else if (resp_done && more_beats) begin
      beats_q <= beats_q - 8'd1;
    end
  end
`else
  logic [7:0] unused_req_len;

  assign more_beats     = 1'b0;
  assign unused_req_len = req_len;
`endif

  // State and phase counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = we_q ? S_HOLD : S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      S_RESP: begin
        if (rd_ready) begin
          if (more_beats) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_ready <= 1'b0;
      rd_valid  <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      drv_en_q  <= 1'b0;
    end else begin
      req_ready <= (state_d == S_IDLE);
      rd_valid  <= (state_d == S_RESP);
      ram_cs    <= (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      ram_we    <= (state_d == S_STROBE) && we_d;
      ram_oe    <= (state_d == S_STROBE) && !we_d;
      drv_en_q  <= we_d && ((state_d == S_SETUP) || (state_d == S_STROBE) ||
                            (state_d == S_HOLD));
    end
  end

  // Request fields are captured only at acceptance; burst beats step the address.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ram_addr <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      wdata_q  <= req_wdata;
      ram_addr <= req_addr;
    end else if (resp_done && more_beats) begin
      ram_addr <= ram_addr + 1'b1;
    end
  end

  // Read word is captured on the edge that ends the final strobe cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data <= '0;
    end else if (last_strobe && !we_q) begin
      rd_data <= ram_data;
    end
  end

endmodule

// File: tb/tb_ram_port_seq.sv
// Bench for ram_port_seq: randomized writes/reads against a memory model,
// directed latency, hold, back-to-back, reset-abort and wrap scenarios, plus
// a second instance with stretched setup/strobe timing.
module tb_ram_port_seq;

  localparam int S  = 1;
  localparam int ST = 2;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata, req_len;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data, ram_addr;
  wire  [7:0] ram_data;
  logic       ram_cs, ram_we, ram_oe;
  logic [2:0] dbg_state;

  logic       req_valid2, req_ready2, req_we2;
  logic [7:0] req_addr2, req_wdata2, req_len2;
  logic       rd_valid2, rd_ready2;
  logic [7:0] rd_data2, ram_addr2;
  wire  [7:0] ram_data2;
  logic       ram_cs2, ram_we2, ram_oe2;
  logic [2:0] dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [256];
  logic [7:0] tb_mem  [256];

  always #5 clk = ~clk;

  ram_port_seq u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .dbg_state(dbg_state)
  );

  ram_port_seq #(.SETUP_CYC(3), .STROBE_CYC(4)) u_dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .req_len(req_len2),
    .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_data(rd_data2),
    .ram_addr(ram_addr2), .ram_data(ram_data2),
    .ram_cs(ram_cs2), .ram_we(ram_we2), .ram_oe(ram_oe2),
    .dbg_state(dbg_state2)
  );

  // Simple asynchronous SRAM: drives data while selected and output-enabled.
  assign ram_data = (ram_cs && ram_oe) ? tb_mem[ram_addr] : 8'bz;

  always @(posedge clk) begin
    if (ram_cs && ram_we) tb_mem[ram_addr] <= ram_data;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int i = 0;
    while (!req_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(req_ready), 32'd1);
  endtask

  // Write; with keep=1 req_valid stays high for a following request.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic keep);
    wait_ready("wr_ready_wait");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_len   = 8'($urandom);
    @(negedge clk);
    req_valid = keep;
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
    req_we    = 1'($urandom_range(0, 1));
    for (int k = 1; k <= S + ST + 1; k++) begin
      check("wr_ctl", 32'({ram_cs, ram_we, ram_oe, req_ready, rd_valid}),
            32'({1'b1, (k > S) && (k <= S + ST), 1'b0, 1'b0, 1'b0}));
      check("wr_data", 32'(ram_data), 32'(d));
      check("wr_addr", 32'(ram_addr), 32'(a));
      @(negedge clk);
    end
    check("wr_done", 32'({ram_cs, ram_we, ram_oe, req_ready}), 32'(4'b0001));
    ref_mem[a] = d;
  endtask

  // Read; hold = cycles rd_ready stays low once rd_valid rises.
  task automatic do_read(input logic [7:0] a, input logic [7:0] len, input int hold);
    int beats;
    logic [7:0] cur;
    cur = a;
`ifdef RAM_PORT_SEQ_BURST_EN
    beats = int'(len) + 1;
`else
    beats = 1;
`endif
    wait_ready("rd_ready_wait");
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_len   = 8'($urandom);
    for (int b = 0; b < beats; b++) begin
      for (int k = 1; k <= S + ST; k++) begin
        check("rd_ctl", 32'({ram_cs, ram_we, ram_oe, req_ready, rd_valid}),
              32'({1'b1, 1'b0, k > S, 1'b0, 1'b0}));
        check("rd_addr", 32'(ram_addr), 32'(cur));
        @(negedge clk);
      end
      check("rd_resp", 32'({ram_cs, ram_we, ram_oe, req_ready, rd_valid}), 32'(5'b00001));
      check("rd_data", 32'(rd_data), 32'(ref_mem[cur]));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("rd_hold", 32'({rd_valid, rd_data}), 32'({1'b1, ref_mem[cur]}));
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      cur = cur + 8'd1;
    end
    check("rd_idle", 32'({ram_cs, ram_oe, req_ready, rd_valid}), 32'(4'b0010));
  endtask

  // Write on the stretched-timing instance and count strobe widths.
  task automatic do_write2(input logic [7:0] a, input logic [7:0] d);
    int cs_n = 0;
    int we_n = 0;
    int oe_n = 0;
    int i = 0;
    while (!req_ready2 && i < 50) begin
      @(negedge clk);
      i++;
    end
    req_valid2 = 1'b1;
    req_we2    = 1'b1;
    req_addr2  = a;
    req_wdata2 = d;
    @(negedge clk);
    req_valid2 = 1'b0;
    i = 0;
    while (!req_ready2 && i < 40) begin
      if (ram_cs2) begin
        cs_n++;
        check("w2_data", 32'(ram_data2), 32'(d));
      end
      if (ram_we2) we_n++;
      if (ram_oe2) oe_n++;
      @(negedge clk);
      i++;
    end
    check("w2_ready", 32'(req_ready2), 32'd1);
    check("w2_cs_cycles", 32'(cs_n), 32'd8);
    check("w2_we_cycles", 32'(we_n), 32'd4);
    check("w2_oe_cycles", 32'(oe_n), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 8'd0; req_len = 8'd0;
    rd_ready = 1'b0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'd0; req_wdata2 = 8'd0; req_len2 = 8'd0;
    rd_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({req_ready, rd_valid, ram_cs, ram_we, ram_oe}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(req_ready), 32'd1);

    // Fill the whole memory so every later read has a known expectation.
    for (int a = 0; a < 256; a++) do_write(8'(a), 8'($urandom), 1'b0);

    // Write 0xA5 to 0x10 with default timing.
    do_write(8'h10, 8'hA5, 1'b0);

    // Read 0x3C from 0x20 with rd_ready held low for 10 cycles.
    do_write(8'h20, 8'h3C, 1'b0);
    do_read(8'h20, 8'd0, 10);

    // Back-to-back write then read with req_valid never dropping.
    do_write(8'h00, 8'h01, 1'b1);
    do_read(8'h00, 8'd0, 0);

    // Wrap-around read: burst build gives three beats, default build one.
    do_write(8'hFE, 8'h11, 1'b0);
    do_write(8'hFF, 8'h22, 1'b0);
    do_write(8'h00, 8'h33, 1'b0);
    do_read(8'hFE, 8'd2, 1);

    // Reset asserted during the strobe of a write.
    wait_ready("abort_ready_wait");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h77; req_wdata = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_strobe", 32'({ram_cs, ram_we}), 32'(2'b11));
    rst_n = 1'b0;
    #1;
    check("abort_ctl", 32'({req_ready, rd_valid, ram_cs, ram_we, ram_oe}), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_rel", 32'({req_ready, rd_valid, ram_cs}), 32'(3'b100));
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 32'({rd_valid, ram_cs}), 32'd0);
    end
    do_write(8'h77, 8'h5A, 1'b0);

    // Randomized mix of writes and reads.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      else
        do_read(8'($urandom), 8'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end
    req_valid = 1'b0;

    // Stretched timing instance.
    do_write2(8'h42, 8'hC3);
    check("dut2_idle", 32'({rd_valid2, rd_data2, dbg_state2}), 32'd0);
    check("dut2_addr", 32'(ram_addr2), 32'h42);
    check("dut2_len_tie", 32'(req_len2), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_port_seq.md
RAM_PORT_SEQ -- requirements
Module: ram_port_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 Parameter SETUP_CYC, default 1, range 1-15, cycles with address and chip-select valid before the strobe.
REQ-004 Parameter STROBE_CYC, default 2, range 1-15, cycles of we/oe strobe.
REQ-005 sys_clk  in  1  single clock; one clock, all logic on its rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  1  request offered.
REQ-008 req_ready  out  1  request accepted when both high at an edge.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_WIDTH  start address.
REQ-011 req_wdata  in  DATA_WIDTH  write data.
REQ-012 req_len  in  8  read beats minus 1; used only per REQ-032.
REQ-013 rd_valid  out  1  read data available.
REQ-014 rd_ready  in  1  consumer accepts rd_data.
REQ-015 rd_data  out  DATA_WIDTH  captured read word.
REQ-016 ram_addr  out  ADDR_WIDTH  RAM port address.
REQ-017 ram_data  inout  DATA_WIDTH  RAM port data; driven only while writing, else high-Z.
REQ-018 ram_cs / ram_we / ram_oe  out  1 each  RAM chip-select, write-enable, output-enable, active-high.

Function
REQ-019 FSM states IDLE, SETUP, STROBE, HOLD, RESP; one state register, one down-counter for cycle counts.
REQ-020 req_ready SHALL be 1 only in IDLE; accept moves to SETUP and latches req_we, req_addr, req_wdata, req_len.
REQ-021 SETUP lasts SETUP_CYC cycles: ram_cs=1, ram_addr valid, ram_we=0, ram_oe=0.
REQ-022 STROBE lasts STROBE_CYC cycles: ram_cs=1, ram_we=1 for writes, ram_oe=1 for reads, never both.
REQ-023 Write: ram_data driven with latched wdata in SETUP, STROBE and HOLD; HOLD is 1 cycle with ram_cs=1, ram_we=0; then IDLE.
REQ-024 Read: ram_data sampled into rd_data at the edge ending the last STROBE cycle; next state RESP; no HOLD for reads.
REQ-025 RESP: rd_valid=1, rd_data stable, ram_cs=ram_oe=0; leave on rd_valid&&rd_ready.
REQ-026 Default latency (SETUP_CYC=1, STROBE_CYC=2), accept at edge T0: write SETUP T1, STROBE T2-T3, HOLD T4, req_ready=1 at T5; read rd_valid=1 from T4.
REQ-027 ram_addr, ram_cs, ram_we, ram_oe SHALL be registered outputs, glitch-free.
REQ-028 ram_data driver enable SHALL never be 1 in a cycle where ram_oe=1.
REQ-029 req_valid dropping without acceptance has no effect; request fields sampled only at acceptance.
REQ-030 rd_ready held low: stay in RESP indefinitely, rd_data unchanged.

Reset
REQ-031 sys_rst_n=0 at any time, including mid-access: state IDLE, counters 0, req_ready=0 while in reset and 1 from first edge after release, rd_valid=0, rd_data=0, ram_addr=0, ram_cs=ram_we=ram_oe=0, ram_data high-Z; aborted access is neither completed nor reported.

Configuration
REQ-032 Macro RAM_PORT_SEQ_BURST_EN defined: read requests perform req_len+1 beats; after each RESP handshake, address increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00) and FSM returns to SETUP; IDLE only after the last beat; writes always single-beat.
REQ-033 RAM_PORT_SEQ_BURST_EN undefined: req_len ignored, every read is one beat; port still present.

Verification
REQ-034 Write 0xA5 to 0x10 with defaults -> ram_cs=1 T1-T4, ram_we=1 exactly T2-T3, ram_data=0xA5 T1-T4 then high-Z, req_ready=1 at T5.
REQ-035 RAM model holds 0x3C at 0x20, read 0x20 -> ram_oe=1 T2-T3, rd_valid=1 T4, rd_data=0x3C; rd_ready low 10 cycles -> rd_valid and rd_data held; then IDLE one cycle after handshake.
REQ-036 Back-to-back write 0x01->0x00 then read 0x00 with req_valid held -> read returns 0x01; no cycle with ram_oe=1 while ram_data driven.
REQ-037 sys_rst_n low during STROBE of a write -> ram_we/ram_cs=0 and ram_data high-Z immediately; after release req_ready=1 and no rd_valid.
REQ-038 With RAM_PORT_SEQ_BURST_EN, read addr 0xFE len 2 -> rd_data from 0xFE, 0xFF, 0x00 in order; without macro same request -> one beat from 0xFE only.
REQ-039 SETUP_CYC=3, STROBE_CYC=4 write -> ram_cs asserted 8 cycles, ram_we exactly 4.
